matrix_keypad_scanner: RTL and testbench
========================================

// Module: matrix_keypad_scanner
// PURPOSE
//  Parametrised ROWS x COLS matrix-keypad scanner for the piano front end; successor to the fixed 4x4 scanner.
//  Drives active-low columns, samples active-low rows, debounces press and release, emits linear key code + strobe.
//  Feeds the note decoder (key_code -> tone select); runs entirely in the system clock domain via a tick enable.
// PARAMETERS
//  ROWS        4    number of row inputs (2..8)
//  COLS        4    number of column outputs (2..8)
//  CLK_DIV     50   clk cycles per scan tick (>=2); tick = 1-cycle enable, no derived clock
//  DEB_TICKS   16   consecutive identical samples required to accept press or release (>=1)
//  REP_DELAY   500  ticks held before first auto-repeat (KPD_AUTOREPEAT_EN only)
//  REP_PERIOD  100  ticks between subsequent repeats (KPD_AUTOREPEAT_EN only)
// PORTS
//  clk        in   1           system clock
//  rst_n      in   1           asynchronous active-low reset
//  row        in   ROWS        row sense, active-low, asynchronous to clk (pulled up)
//  col        out  COLS        column drive, active-low
//  key_code   out  CODE_W      linear index col_idx*ROWS + row_idx; CODE_W = $clog2(ROWS*COLS)
//  key_valid  out  1           1-clk strobe: key_code newly valid (press accepted / repeat)
//  key_down   out  1           high while accepted key is held (press accepted -> release accepted)
//  multi_key  out  1           high while >1 row is low in the locked column
// BEHAVIOUR
//  Reset: col=all 0, key_code=0, key_valid=0, key_down=0, multi_key=0, FSM=IDLE, counters=0, sync flops=all 1.
//  row passes a 2-flop synchroniser; all decisions use the synchronised value (rs). FSM advances only on tick.
//  IDLE : col=all 0. rs!=all1 -> SCAN with c=0, col=~(1<<0). Else stay.
//  SCAN : col=~(1<<c) driven one tick before sampling. rs!=all1 -> DEB_P, lock c, snapshot rs.
//         else c==COLS-1 -> IDLE (glitch/early release), else c++ and drive next column.
//  DEB_P: rs==snapshot -> cnt++; cnt reaches DEB_TICKS -> PRESSED. rs changes -> reload snapshot, cnt=0.
//         rs==all1 at any point -> IDLE (bounce rejected, no strobe).
//  PRESSED entry: key_code = c*ROWS + lowest-index low row; key_valid=1 for exactly one clk; key_down=1.
//         multi_key = (popcount(~rs)>1), updated every tick while PRESSED; lowest row wins the code.
//  PRESSED: rs==all1 -> DEB_R, cnt=0. Other rows changing within locked column do not re-strobe.
//  DEB_R: rs==all1 for DEB_TICKS consecutive ticks -> key_down=0, multi_key=0, IDLE. Any low row -> PRESSED, no strobe.
//  key_code holds last value after release; no backpressure, consumer must sample on key_valid.
//  Keys in other columns are invisible while one column is locked (no n-key rollover).
//  Tick counter: 0..CLK_DIV-1, tick when count==CLK_DIV-1, wraps to 0. Debounce counter saturates, width $clog2(DEB_TICKS+1).
//  rst_n low mid-scan: immediate return to reset values, no strobe emitted.
// CONFIGURATION
//  `define KPD_AUTOREPEAT_EN: in PRESSED, after REP_DELAY ticks held, key_valid re-pulses (same key_code) every REP_PERIOD ticks
//   until DEB_R entered; repeat counter cleared on leaving PRESSED. A bounce through DEB_R back to PRESSED restarts REP_DELAY.
//  Not defined: exactly one key_valid per accepted press; repeat counter and parameters unused/removed.
// STRUCTURE
//  Package kpd_pkg: state enum (IDLE,SCAN,DEB_P,PRESSED,DEB_R), function code_w(rows,cols), lowest_zero(ROWS) priority fn.
//  Sub-module kpd_tick_gen (CLK_DIV): counter + 1-clk tick enable; reused by the tone generator.
//  Top holds synchroniser, FSM, column/debounce/repeat counters, output registers.
// TESTING (ROWS=4, COLS=4, CLK_DIV=4, DEB_TICKS=3, REP_DELAY=10, REP_PERIOD=5 in bench)
//  Clean press col2,row1 held 20 ticks -> one key_valid, key_code=9, key_down=1; release -> key_down=0 after 3 ticks.
//  Bouncy press (row toggles every tick for 5 ticks, then stable) -> single strobe only after 3 stable ticks; no extra strobes.
//  1-tick glitch on row0 -> no key_valid, FSM back to IDLE, col=4'b0000.
//  Col0 rows0+2 low -> key_code=0, multi_key=1; release row0 only -> no new strobe, multi_key=0.
//  rst_n asserted during DEB_P -> all outputs reset next edge, no key_valid; after release, fresh press scans normally.
//  KPD_AUTOREPEAT_EN: hold col3,row3 for 30 ticks -> strobes at accept, +10, +15, +20, +25, +30 ticks, key_code=15 each;
//   without macro same stimulus -> exactly one strobe.

Source files
------------

// File: rtl/kpd_pkg.sv
// rtl/kpd_pkg.sv - shared FSM encodings and helper functions for the keypad scanner
`timescale 1ns/1ps
package kpd_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SCAN    = 3'd1;
    localparam logic [2:0] ST_DEB_P   = 3'd2;
    localparam logic [2:0] ST_PRESSED = 3'd3;
    localparam logic [2:0] ST_DEB_R   = 3'd4;

    function automatic int code_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    // Index of the lowest active-low bit among the first 'rows' bits; 0 when none.
    function automatic logic [2:0] lowest_zero(input logic [7:0] v, input int rows);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i < rows && !v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/matrix_keypad_scanner_if.sv
// rtl/matrix_keypad_scanner_if.sv - key event bundle from the scanner to the note decoder
`timescale 1ns/1ps
interface matrix_keypad_scanner_if #(
    parameter int CODE_W = 4
);
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_down;
    logic              multi_key;

    modport master (output key_code, key_valid, key_down, multi_key);
    modport slave  (input  key_code, key_valid, key_down, multi_key);
endinterface

// File: rtl/kpd_tick_gen.sv
// rtl/kpd_tick_gen.sv - free-running divider producing a one-clock tick enable every CLK_DIV cycles
`timescale 1ns/1ps
module kpd_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(CLK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/matrix_keypad_scanner.sv
// rtl/matrix_keypad_scanner.sv - ROWS x COLS keypad scanner with press/release debounce
// Optional auto-repeat while held: define KPD_AUTOREPEAT_EN.
`timescale 1ns/1ps
module matrix_keypad_scanner
    import kpd_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int CLK_DIV    = 50,
    parameter int DEB_TICKS  = 16,
    parameter int REP_DELAY  = 500,
    parameter int REP_PERIOD = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROWS-1:0]        row,
    output logic [COLS-1:0]        col,
    matrix_keypad_scanner_if.master kpd
);
    localparam int CODE_W = code_w(ROWS, COLS);
    localparam int CI_W   = $clog2(COLS);
    localparam int DW     = $clog2(DEB_TICKS + 1);

    logic              tick;
    logic [ROWS-1:0]   rs1_q, rs1_d, rs_q, rs_d, snap_q, snap_d;
    logic [2:0]        state_q, state_d;
    logic [CI_W-1:0]   c_q, c_d;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic [COLS-1:0]   col_q, col_d;
    logic [CODE_W-1:0] code_q, code_d, press_code;
    logic              valid_q, valid_d, down_q, down_d, multi_q, multi_d;
    logic              rs_idle, multi_now;
    logic [ROWS-1:0]   nrs;
    logic [7:0]        rs_pad;

`ifdef KPD_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_arm_q, rep_arm_d;
`else
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{REP_DELAY, REP_PERIOD};
`endif

    kpd_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

    always_comb begin
        rs1_d   = row;
        rs_d    = rs1_q;
        state_d = state_q;
        c_d     = c_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;
        multi_d = multi_q;
`ifdef KPD_AUTOREPEAT_EN
        rep_d     = rep_q;
        rep_arm_d = rep_arm_q;
`endif
        rs_pad           = '1;
        rs_pad[ROWS-1:0] = rs_q;
        rs_idle    = (rs_q == '1);
        nrs        = ~rs_q;
        // Clearing the lowest set bit leaves something only if two or more rows are low.
        multi_now  = |(nrs & (nrs - ROWS'(1)));
        press_code = CODE_W'(c_q) * CODE_W'(ROWS) + CODE_W'(lowest_zero(rs_pad, ROWS));

        if (tick) begin
`ifdef KPD_AUTOREPEAT_EN
            rep_d     = '0;
            rep_arm_d = 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    col_d = '0;
                    if (!rs_idle) begin
                        state_d = ST_SCAN;
                        c_d     = '0;
                        col_d   = ~COLS'(1);
                    end
                end
                ST_SCAN: begin
                    if (!rs_idle) begin
                        state_d = ST_DEB_P;
                        snap_d  = rs_q;
                        cnt_d   = '0;
                    end else if (c_q == CI_W'(COLS - 1)) begin
                        state_d = ST_IDLE;
                        col_d   = '0;
                    end else begin
                        c_d   = c_q + CI_W'(1);
                        col_d = ~(COLS'(1) << (c_q + CI_W'(1)));
                    end
                end
                ST_DEB_P: begin
                    if (rs_idle) begin
                        state_d = ST_IDLE;
                        col_d   = '0;
                    end else if (rs_q != snap_q) begin
                        snap_d = rs_q;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = (cnt_q == DW'(DEB_TICKS)) ? cnt_q : cnt_q + DW'(1);
                        if (cnt_q == DW'(DEB_TICKS - 1)) begin
                            state_d = ST_PRESSED;
                            code_d  = press_code;
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            multi_d = multi_now;
                        end
                    end
                end
                ST_PRESSED: begin
                    multi_d = multi_now;
                    if (rs_idle) begin
                        state_d = ST_DEB_R;
                        cnt_d   = '0;
                    end else begin
`ifdef KPD_AUTOREPEAT_EN
                        rep_d     = rep_q + RW'(1);
                        rep_arm_d = rep_arm_q;
                        if (rep_d == (rep_arm_q ? RW'(REP_PERIOD) : RW'(REP_DELAY))) begin
                            valid_d   = 1'b1;
                            rep_d     = '0;
                            rep_arm_d = 1'b1;
                        end
`endif
                    end
                end
                ST_DEB_R: begin
                    if (!rs_idle) begin
                        state_d = ST_PRESSED;
                        multi_d = multi_now;
                    end else begin
                        cnt_d = (cnt_q == DW'(DEB_TICKS)) ? cnt_q : cnt_q + DW'(1);
                        if (cnt_q == DW'(DEB_TICKS - 1)) begin
                            state_d = ST_IDLE;
                            down_d  = 1'b0;
                            multi_d = 1'b0;
                            col_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q   <= '1;
            rs_q    <= '1;
            snap_q  <= '1;
            state_q <= ST_IDLE;
            c_q     <= '0;
            cnt_q   <= '0;
            col_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            rs1_q   <= rs1_d;
            rs_q    <= rs_d;
            snap_q  <= snap_d;
            state_q <= state_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
            multi_q <= multi_d;
        end
    end

`ifdef KPD_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q     <= '0;
            rep_arm_q <= 1'b0;
        end else begin
            rep_q     <= rep_d;
            rep_arm_q <= rep_arm_d;
        end
    end
`endif

    assign col           = col_q;
    assign kpd.key_code  = code_q;
    assign kpd.key_valid = valid_q;
    assign kpd.key_down  = down_q;
    assign kpd.multi_key = multi_q;
endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// tb/tb_matrix_keypad_scanner.sv - directed self-checking bench with a behavioural 4x4 key matrix
`timescale 1ns/1ps
module tb_matrix_keypad_scanner;
    localparam int TICK_CLKS = 4;

    typedef struct {
        int         c;
        int         r;
        logic [3:0] code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] keymask;
    logic [3:0]  glitch;

    int     checks = 0;
    int     errors = 0;
    int     strobes = 0;
    longint stamps[$];

    matrix_keypad_scanner_if #(.CODE_W(4)) kif ();

    matrix_keypad_scanner #(
        .ROWS(4), .COLS(4), .CLK_DIV(TICK_CLKS), .DEB_TICKS(3),
        .REP_DELAY(10), .REP_PERIOD(5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .row   (row),
        .col   (col),
        .kpd   (kif)
    );

    always #5 clk = ~clk;

    // A closed key pulls its row low whenever its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = ~glitch[r];
            for (int c = 0; c < 4; c++) begin
                if (keymask[c*4+r] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (kif.key_valid) begin
            strobes++;
            stamps.push_back($time);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * TICK_CLKS) @(negedge clk);
    endtask

    vec_t vecs[6];
    int   n0;

    initial begin
        vecs[0] = '{c: 2, r: 1, code: 4'd9};
        vecs[1] = '{c: 0, r: 0, code: 4'd0};
        vecs[2] = '{c: 3, r: 3, code: 4'd15};
        vecs[3] = '{c: 1, r: 2, code: 4'd6};
        vecs[4] = '{c: 0, r: 3, code: 4'd3};
        vecs[5] = '{c: 3, r: 0, code: 4'd12};

        rst_n   = 1'b0;
        keymask = '0;
        glitch  = '0;
        repeat (3) @(negedge clk);
        check("rst_col", col, 4'b0000);
        check("rst_code", kif.key_code, 0);
        check("rst_valid", kif.key_valid, 0);
        check("rst_down", kif.key_down, 0);
        check("rst_multi", kif.multi_key, 0);
        rst_n = 1'b1;
        ticks(2);

        foreach (vecs[i]) begin
            n0 = strobes;
            keymask[vecs[i].c*4+vecs[i].r] = 1'b1;
            ticks(12);
            check($sformatf("v%0d_strobes", i), strobes, n0 + 1);
            check($sformatf("v%0d_code", i), kif.key_code, vecs[i].code);
            check($sformatf("v%0d_down", i), kif.key_down, 1);
            check($sformatf("v%0d_multi", i), kif.multi_key, 0);
            keymask = '0;
            ticks(1);
            check($sformatf("v%0d_down_deb", i), kif.key_down, 1);
            ticks(7);
            check($sformatf("v%0d_released", i), kif.key_down, 0);
            check($sformatf("v%0d_code_hold", i), kif.key_code, vecs[i].code);
            check($sformatf("v%0d_no_extra", i), strobes, n0 + 1);
            check($sformatf("v%0d_col_idle", i), col, 4'b0000);
        end

        // Reset while debouncing a press: no strobe, outputs cleared.
        n0 = strobes;
        keymask[0] = 1'b1;
        repeat (3 * TICK_CLKS) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstdeb_code", kif.key_code, 0);
        check("rstdeb_down", kif.key_down, 0);
        check("rstdeb_col", col, 4'b0000);
        keymask = '0;
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        check("rstdeb_no_strobe", strobes, n0);
        keymask[1*4+2] = 1'b1;
        ticks(12);
        check("rstdeb_fresh_strobes", strobes, n0 + 1);
        check("rstdeb_fresh_code", kif.key_code, 6);
        keymask = '0;
        ticks(8);

        // Bouncy press on col2,row1.
        n0 = strobes;
        for (int b = 0; b < 4; b++) begin
            keymask[2*4+1] = (b % 2 == 0);
            ticks(1);
        end
        check("bounce_no_early", strobes, n0);
        keymask[2*4+1] = 1'b1;
        ticks(12);
        check("bounce_strobes", strobes, n0 + 1);
        check("bounce_code", kif.key_code, 9);
        keymask = '0;
        ticks(8);
        check("bounce_after_release", strobes, n0 + 1);

        // Single-tick glitch on row0.
        n0 = strobes;
        glitch[0] = 1'b1;
        ticks(1);
        glitch[0] = 1'b0;
        ticks(8);
        check("glitch_strobes", strobes, n0);
        check("glitch_col", col, 4'b0000);
        check("glitch_down", kif.key_down, 0);

        // Two rows in column 0: lowest row wins, multi_key tracks.
        n0 = strobes;
        keymask[0*4+0] = 1'b1;
        keymask[0*4+2] = 1'b1;
        ticks(8);
        check("multi_strobes", strobes, n0 + 1);
        check("multi_code", kif.key_code, 0);
        check("multi_flag", kif.multi_key, 1);
        keymask[0*4+0] = 1'b0;
        ticks(3);
        check("multi_clear", kif.multi_key, 0);
        check("multi_still_down", kif.key_down, 1);
        check("multi_no_restrobe", strobes, n0 + 1);
        keymask = '0;
        ticks(8);
        check("multi_released", kif.key_down, 0);

        // Long hold on col3,row3.
        n0 = strobes;
        keymask[3*4+3] = 1'b1;
        for (int w = 0; w < 20 * TICK_CLKS && strobes == n0; w++) @(negedge clk);
        check("hold_accept", strobes, n0 + 1);
        ticks(31);
        keymask = '0;
        ticks(8);
        check("hold_code", kif.key_code, 15);
`ifdef KPD_AUTOREPEAT_EN
        check("hold_strobes", strobes, n0 + 6);
        if (stamps.size() >= n0 + 3) begin
            check("hold_first_gap", stamps[n0+1] - stamps[n0], 10 * TICK_CLKS * 10);
            check("hold_period_gap", stamps[n0+2] - stamps[n0+1], 5 * TICK_CLKS * 10);
        end
`else
        check("hold_strobes", strobes, n0 + 1);
`endif
        check("hold_released", kif.key_down, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
